// File: rtl/point_ctrl.sv
// Score keeper and serve/hold sequencer for a two-player paddle game.
// Tracks points, holds the ball for a fixed number of frames after each point, and flags the winner.
module point_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       frame_tick,
  input  logic       miss1,
  input  logic       miss2,
  output logic       still,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] POINT = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam logic [4:0] WIN  = 5'(WIN_SCORE);
  localparam logic [8:0] HOLD = 9'(HOLD_FRAMES);

  logic [1:0] state;
  logic [7:0] hold_cnt;

  logic       sync1;
  logic       sync2;
  logic       delay;
  logic [1:0] settle;
  logic       armed;
  logic       start_edge;

  logic [4:0] inc1;
  logic [4:0] inc2;
  logic [8:0] hold_next;

  // The edge detector stays disarmed until the synchronizer has seen the button
  // released after reset, so a button held through reset release cannot start a game.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      delay  <= 1'b0;
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      sync1 <= btn_start;
      sync2 <= sync1;
      delay <= sync2;
      if (settle != 2'd2)
        settle <= settle + 2'd1;
      if (settle == 2'd2 && !sync2)
        armed <= 1'b1;
    end
  end

  assign start_edge = sync2 & ~delay & armed;

  assign inc1      = {1'b0, score1} + 5'd1;
  assign inc2      = {1'b0, score2} + 5'd1;
  assign hold_next = {1'b0, hold_cnt} + 9'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      still     <= 1'b1;
      score1    <= 4'd0;
      score2    <= 4'd0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      hold_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= PLAY;
            still  <= 1'b0;
            score1 <= 4'd0;
            score2 <= 4'd0;
            winner <= 1'b0;
          end
        end

        // A simultaneous double miss is credited to player 2 only.
        PLAY: begin
          if (miss1) begin
            score2 <= inc2[3:0];
            still  <= 1'b1;
            if (inc2 == WIN) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              state    <= POINT;
              hold_cnt <= 8'd0;
            end
          end else if (miss2) begin
            score1 <= inc1[3:0];
            still  <= 1'b1;
            if (inc1 == WIN) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              state    <= POINT;
              hold_cnt <= 8'd0;
            end
          end
        end

        POINT: begin
          if (frame_tick) begin
            hold_cnt <= hold_next[7:0];
            if (hold_next == HOLD) begin
              state <= PLAY;
              still <= 1'b0;
            end
          end
        end

        OVER: begin
          if (start_edge) begin
            state     <= PLAY;
            still     <= 1'b0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          still <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_point_ctrl.sv
// Scoreboard bench for point_ctrl: every expected output change is queued with its cycle
// when stimulus is driven, and the monitor pops one entry per observed output change.
module tb_point_ctrl;

  localparam int WIN = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       btn_start;
  logic       frame_tick;
  logic       miss1;
  logic       miss2;
  logic       still;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;
  logic       winner;

  logic       btn_b;
  logic       tick_b;
  logic       miss1_b;
  logic       miss2_b;
  logic       still_b;
  logic [3:0] s1_b;
  logic [3:0] s2_b;
  logic       over_b;
  logic       winner_b;
  logic       still_c;
  logic [3:0] s1_c;
  logic [3:0] s2_c;
  logic       over_c;
  logic       winner_c;

  point_ctrl dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .frame_tick(frame_tick),
    .miss1(miss1), .miss2(miss2), .still(still), .score1(score1), .score2(score2),
    .game_over(game_over), .winner(winner)
  );

  point_ctrl #(.WIN_SCORE(1), .HOLD_FRAMES(1)) dut_b (
    .clk(clk), .reset(reset), .btn_start(btn_b), .frame_tick(tick_b),
    .miss1(miss1_b), .miss2(miss2_b), .still(still_b), .score1(s1_b), .score2(s2_b),
    .game_over(over_b), .winner(winner_b)
  );

  point_ctrl #(.WIN_SCORE(15), .HOLD_FRAMES(1)) dut_c (
    .clk(clk), .reset(reset), .btn_start(btn_b), .frame_tick(tick_b),
    .miss1(miss1_b), .miss2(miss2_b), .still(still_c), .score1(s1_c), .score2(s2_c),
    .game_over(over_c), .winner(winner_c)
  );

  logic [10:0] main_vec;
  logic [10:0] vec_b;
  logic [10:0] vec_c;
  assign main_vec = {still, score1, score2, game_over, winner};
  assign vec_b    = {still_b, s1_b, s2_b, over_b, winner_b};
  assign vec_c    = {still_c, s1_c, s2_c, over_c, winner_c};

  typedef struct {
    int          cyc;
    logic [10:0] vec;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int num_checks = 0;
  int num_fails  = 0;

  logic        mon_en = 1'b0;
  logic [10:0] prev_vec;

  logic       m_still;
  logic [3:0] m_s1;
  logic [3:0] m_s2;
  logic       m_over;
  logic       m_win;

  function automatic logic [10:0] pk(input logic st, input logic [3:0] a, input logic [3:0] b,
                                     input logic go, input logic w);
    return {st, a, b, go, w};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    num_checks++;
    if (got !== expv) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // One scoreboard entry per output change; a change with nothing queued is itself an error.
  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (mon_en && main_vec !== prev_vec) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_change", 32'(main_vec), 32'(prev_vec));
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput(t, 32'(main_vec), 32'(e.vec));
        if (e.cyc >= 0)
          checkOutput({t, "_cyc"}, 32'(cyc), 32'(e.cyc));
      end
      prev_vec = main_vec;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input string t, input int c);
    exp_t e;
    e.cyc = c;
    e.vec = pk(m_still, m_s1, m_s2, m_over, m_win);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic applyStimulus(input string tag, input logic m1, input logic m2,
                               input int hold, input logic ft);
    logic [4:0] n;
    if (m1) begin
      n = {1'b0, m_s2} + 5'd1;
      m_s2 = n[3:0];
      if (n == 5'(WIN)) begin
        m_over = 1'b1;
        m_win  = 1'b1;
      end
    end else if (m2) begin
      n = {1'b0, m_s1} + 5'd1;
      m_s1 = n[3:0];
      if (n == 5'(WIN)) begin
        m_over = 1'b1;
        m_win  = 1'b0;
      end
    end
    m_still = 1'b1;
    push_exp(tag, cyc + 1);
    miss1      = m1;
    miss2      = m2;
    frame_tick = ft;
    step();
    frame_tick = 1'b0;
    repeat (hold - 1) step();
    miss1 = 1'b0;
    miss2 = 1'b0;
    step();
  endtask

  task automatic hold_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      if (i == n - 1) begin
        m_still = 1'b0;
        push_exp(tag, cyc + 1);
      end
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic start_pulse(input string tag);
    btn_start = 1'b1;
    m_still = 1'b0;
    m_s1    = 4'd0;
    m_s2    = 4'd0;
    m_over  = 1'b0;
    m_win   = 1'b0;
    push_exp(tag, cyc + 3);
    repeat (5) step();
    btn_start = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    reset      = 1'b1;
    btn_start  = 1'b0;
    frame_tick = 1'b0;
    miss1      = 1'b0;
    miss2      = 1'b0;
    btn_b      = 1'b0;
    tick_b     = 1'b0;
    miss1_b    = 1'b0;
    miss2_b    = 1'b0;
    m_still    = 1'b1;
    m_s1       = 4'd0;
    m_s2       = 4'd0;
    m_over     = 1'b0;
    m_win      = 1'b0;

    #3 reset = 1'b0;
    #20;
    checkOutput("reset_state", 32'(main_vec), 32'(pk(1'b1, 4'd0, 4'd0, 1'b0, 1'b0)));
    step();
    reset = 1'b1;
    repeat (5) step();
    prev_vec = main_vec;
    mon_en   = 1'b1;

    start_pulse("start");
    applyStimulus("miss2_point", 1'b0, 1'b1, 5, 1'b1);
    hold_ticks("resume_60", 60);
    applyStimulus("both_miss", 1'b1, 1'b1, 1, 1'b0);
    hold_ticks("resume_both", 60);
    applyStimulus("miss2_2_1", 1'b0, 1'b1, 1, 1'b0);
    hold_ticks("resume_2_1", 60);
    applyStimulus("miss2_3_1", 1'b0, 1'b1, 1, 1'b0);
    hold_ticks("resume_3_1", 60);
    applyStimulus("miss1_3_2", 1'b1, 1'b0, 1, 1'b0);

    // Asynchronous reset in the middle of a POINT hold, with the button already pressed.
    #1;
    m_still = 1'b1;
    m_s1    = 4'd0;
    m_s2    = 4'd0;
    m_over  = 1'b0;
    m_win   = 1'b0;
    push_exp("reset_async", -1);
    reset     = 1'b0;
    btn_start = 1'b1;
    #1;
    checkOutput("reset_immediate", 32'(main_vec), 32'(pk(1'b1, 4'd0, 4'd0, 1'b0, 1'b0)));
    step();
    step();
    reset = 1'b1;
    repeat (8) step();
    btn_start = 1'b0;
    repeat (5) step();

    start_pulse("start_after_reset");
    for (int k = 0; k < 6; k++) begin
      applyStimulus("miss2_run", 1'b0, 1'b1, 1, 1'b0);
      hold_ticks("resume_run", 60);
    end
    applyStimulus("win_p1", 1'b0, 1'b1, 1, 1'b0);

    miss1      = 1'b1;
    miss2      = 1'b1;
    frame_tick = 1'b1;
    repeat (10) step();
    miss1      = 1'b0;
    miss2      = 1'b0;
    frame_tick = 1'b0;
    step();

    start_pulse("restart");
    repeat (3) step();

    btn_b = 1'b1;
    step();
    step();
    checkOutput("small_still_early", 32'(still_b), 32'd1);
    step();
    checkOutput("small_still_b", 32'(still_b), 32'd0);
    checkOutput("small_still_c", 32'(still_c), 32'd0);
    repeat (3) step();
    btn_b = 1'b0;
    step();
    miss2_b = 1'b1;
    step();
    miss2_b = 1'b0;
    checkOutput("win1_over_b", 32'(vec_b), 32'(pk(1'b1, 4'd1, 4'd0, 1'b1, 1'b0)));
    checkOutput("win15_point_c", 32'(vec_c), 32'(pk(1'b1, 4'd1, 4'd0, 1'b0, 1'b0)));
    tick_b = 1'b1;
    step();
    tick_b = 1'b0;
    checkOutput("one_tick_c", 32'(vec_c), 32'(pk(1'b0, 4'd1, 4'd0, 1'b0, 1'b0)));
    checkOutput("over_hold_b", 32'(vec_b), 32'(pk(1'b1, 4'd1, 4'd0, 1'b1, 1'b0)));
    step();

    checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/point_ctrl.md
POINT_CTRL -- requirements
Module: point_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win; legal range 1..15.
REQ-002 SHALL have parameter HOLD_FRAMES, default 60, frame ticks the ball is held after a point; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_start  input  1  raw start/serve button, asynchronous to clk.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per frame (pix_y==480 & pix_x==0).
REQ-007 SHALL have port miss1  input  1  level, player 1 missed the ball.
REQ-008 SHALL have port miss2  input  1  level, player 2 missed the ball.
REQ-009 SHALL have port still  output  1  registered; freezes paddles and centres ball in the graphics stage.
REQ-010 SHALL have port score1  output  4  registered, unsigned points of player 1.
REQ-011 SHALL have port score2  output  4  registered, unsigned points of player 2.
REQ-012 SHALL have port game_over  output  1  registered, high in OVER state.
REQ-013 SHALL have port winner  output  1  registered; 0 = player 1, 1 = player 2; valid only while game_over=1.

Function
REQ-014 SHALL pass btn_start through a two-flop synchronizer plus one delay flop; start_edge = sync2 & ~delay; no debounce.
REQ-015 SHALL implement FSM states IDLE, PLAY, POINT, OVER.
REQ-016 SHALL drive still = 1 in IDLE, POINT and OVER, and 0 only in PLAY, registered with the state.
REQ-017 IDLE: start_edge -> PLAY; all other inputs ignored.
REQ-018 PLAY: miss1=1 -> score2 += 1; else miss2=1 -> score1 += 1; both high in the same cycle -> only score2 increments (miss1 priority).
REQ-019 PLAY: the score update and next-state decision take effect on the same clock edge on which the miss is sampled, i.e. still rises 1 cycle after miss assertion.
REQ-020 PLAY: if the incremented score equals WIN_SCORE -> OVER with winner set to the scoring player; otherwise -> POINT.
REQ-021 POINT: an 8-bit hold counter SHALL clear on entry and increment on each frame_tick; on the frame_tick that brings it to HOLD_FRAMES -> PLAY.
REQ-022 POINT: miss1, miss2 and start_edge SHALL be ignored.
REQ-023 OVER: scores and winner SHALL hold; start_edge -> PLAY with score1=score2=0 and winner=0 on the same edge.
REQ-024 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-025 frame_tick coincident with a miss in PLAY SHALL have no extra effect.

Reset
REQ-026 reset=0 SHALL asynchronously force: state IDLE, still=1, score1=0, score2=0, game_over=0, winner=0, hold counter 0, synchronizer flops 0.
REQ-027 Reset asserted mid-game SHALL abandon the game; the first start_edge after release begins a new game from 0-0.
REQ-028 btn_start held high through reset release SHALL NOT produce a start_edge.

Verification
REQ-029 Reset release, btn_start pulse high 5 cycles -> still falls exactly 3 clk edges after btn_start rises; state PLAY; scores 0-0.
REQ-030 PLAY, miss2 high 1 cycle -> next edge score1=1, still=1; after exactly 60 frame_tick pulses still=0; miss held during POINT ignored.
REQ-031 PLAY, miss1 and miss2 high together -> score2 increments to 1, score1 stays 0.
REQ-032 Score 6-0, miss2 -> score1=7, game_over=1, winner=0, still=1; further misses and frame_ticks change nothing; start pulse -> 0-0, game_over=0, still=0.
REQ-033 Score 3-2 in POINT, reset pulsed low 2 cycles asynchronously between clk edges -> outputs at reset values immediately; btn_start held high across release gives no start.
REQ-034 WIN_SCORE=1, HOLD_FRAMES=1 -> single miss ends game; in a separate POINT run, one frame_tick returns to PLAY.
